// File: rtl/timer_led_ctrl.sv
// Multi-channel down-counting timer with LED toggle, IRQ and delayed core reset.
// Latency: bus writes act at the sampling edge; read data is registered one cycle after sel.
// Backpressure: none, so every sel strobe is accepted in the cycle it is presented.
module timer_led_ctrl #(
    parameter int  CHANNELS        = 2,
    parameter int  TIMER_BITS      = 24,
    parameter int  RESET_DELAY_BIT = 3,
    localparam int AW              = $clog2(CHANNELS) + 2
) (
    input  logic                clk,
    input  logic                nreset,
    output logic                cpu_nreset,
    input  logic                sel,
    input  logic                wr,
    input  logic [AW-1:0]       addr,
    input  logic [31:0]         wdata,
    output logic [31:0]         rdata,
    output logic                rvalid,
    output logic [CHANNELS-1:0] led,
    output logic                irq
);

    logic [TIMER_BITS-1:0]    load_q  [CHANNELS];
    logic [TIMER_BITS-1:0]    count_q [CHANNELS];
    logic [CHANNELS-1:0]      en_q, per_q, ie_q, flag_q;
    logic [CHANNELS-1:0]      wr_hit, ctrl_wr, en_after, per_after, cnt_zero, expire, start;
    logic [AW-1:0]            ch_sel;
    logic [1:0]               rsel;
    logic [31:0]              rd_mux;
    logic [RESET_DELAY_BIT:0] dly_q;
    logic                     unused_wdata;

    assign ch_sel       = addr >> 2;
    assign rsel         = addr[1:0];
    assign unused_wdata = ^wdata;

    always_comb begin
        wr_hit   = '0;
        cnt_zero = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            wr_hit[c]   = sel & wr & (ch_sel == AW'(c));
            cnt_zero[c] = (count_q[c] == '0);
        end
    end

    // A CTRL write that drops enable pre-empts an expiry on the same edge.
    assign ctrl_wr   = wr_hit & {CHANNELS{rsel == 2'd1}};
    assign en_after  = (ctrl_wr & {CHANNELS{wdata[0]}}) | (~ctrl_wr & en_q);
    assign per_after = (ctrl_wr & {CHANNELS{wdata[1]}}) | (~ctrl_wr & per_q);
    assign expire    = en_q & en_after & cnt_zero;
    assign start     = ctrl_wr & {CHANNELS{wdata[0]}} & ~en_q;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            for (int c = 0; c < CHANNELS; c++) begin
                load_q[c]  <= '0;
                count_q[c] <= '0;
            end
            en_q   <= '0;
            per_q  <= '0;
            ie_q   <= '0;
            flag_q <= '0;
            led    <= '0;
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (wr_hit[c] && rsel == 2'd0)
                    load_q[c] <= wdata[TIMER_BITS-1:0];
                if (ctrl_wr[c]) begin
                    en_q[c]  <= wdata[0];
                    per_q[c] <= wdata[1];
                    ie_q[c]  <= wdata[2];
                end
                // Clear is placed before the expiry set so a same-edge set wins.
                if (wr_hit[c] && rsel == 2'd2 && wdata[0])
                    flag_q[c] <= 1'b0;
                if (start[c]) begin
                    count_q[c] <= load_q[c];
                end else if (expire[c]) begin
                    flag_q[c] <= 1'b1;
                    led[c]    <= ~led[c];
                    if (per_after[c])
                        count_q[c] <= load_q[c];
                    else
                        en_q[c] <= 1'b0;
                end else if (en_q[c] && en_after[c]) begin
                    count_q[c] <= count_q[c] - 1'b1;
                end
            end
        end
    end

    always_comb begin
        rd_mux = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (ch_sel == AW'(c)) begin
                case (rsel)
                    2'd0:    rd_mux[TIMER_BITS-1:0] = load_q[c];
                    2'd1:    rd_mux[2:0]            = {ie_q[c], per_q[c], en_q[c]};
                    2'd2:    rd_mux[0]              = flag_q[c];
                    default: rd_mux[TIMER_BITS-1:0] = count_q[c];
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            rdata  <= '0;
            rvalid <= 1'b0;
        end else begin
            rvalid <= sel & ~wr;
            if (sel && !wr)
                rdata <= rd_mux;
        end
    end

    // Saturates once the top bit sets, giving a single clean release of the core.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset)
            dly_q <= '0;
        else if (!dly_q[RESET_DELAY_BIT])
            dly_q <= dly_q + 1'b1;
    end

    assign cpu_nreset = dly_q[RESET_DELAY_BIT];
    assign irq        = |(flag_q & ie_q);

endmodule

// File: doc/timer_led_ctrl.md
# timer_led_ctrl

Parametrised multi-channel timer peripheral for the Tiny32 blink platform. It is the successor to the single fixed-rate blink timer plus power-on reset delay. Each channel has a programmable reload value, a one-shot or periodic mode, an expiry flag, an interrupt enable and an LED toggle output. It sits on the CPU data bus as a memory-mapped slave and also generates the delayed CPU reset.

## Interface

Parameters:

- CHANNELS, 2, number of independent timer channels (1..8)
- TIMER_BITS, 24, counter and reload width (1..32)
- RESET_DELAY_BIT, 3, cpu_nreset releases after 2^RESET_DELAY_BIT clocks

Ports:

- clk  in  1  single clock, all logic on rising edge
- nreset  in  1  asynchronous, active-low reset
- cpu_nreset  out  1  delayed, synchronously released reset for the core
- sel  in  1  bus access strobe, one cycle per access
- wr  in  1  1 = write, 0 = read (qualified by sel)
- addr  in  $clog2(CHANNELS)+2  {channel, reg[1:0]}
- wdata  in  32  write data
- rdata  out  32  read data, registered
- rvalid  out  1  read data valid pulse
- led  out  CHANNELS  per-channel toggle output
- irq  out  1  OR over channels of (flag & irq_en)

## Operation

Per-channel registers, selected by reg:

- 0 LOAD: R/W, TIMER_BITS wide. Upper bits read 0; write is truncated.
- 1 CTRL: R/W.
  - bit0 enable
  - bit1 periodic (1) / one-shot (0)
  - bit2 irq_en
  - other bits read 0
- 2 STATUS: bit0 flag. Write 1 clears it; write 0 has no effect.
- 3 COUNT: read-only current counter. Writes are ignored.
- Channel index ≥ CHANNELS: reads return 0, writes are ignored.

Counter behaviour:

- A CTRL write that sets enable while it was 0 loads COUNT from LOAD in the same edge.
- A CTRL write that keeps enable at 1 does not reload.
- While enabled and COUNT ≠ 0, COUNT decrements by 1 each cycle.
- Expiry: enabled and COUNT == 0. On that edge:
  - flag is set
  - led[ch] toggles
  - periodic: COUNT reloads from LOAD
  - one-shot: enable clears and COUNT stays 0
- Period is LOAD+1 cycles. LOAD=0 in periodic mode expires every cycle.
- A LOAD write during counting affects only the next reload.
- Clearing enable freezes COUNT. flag and led are held.

Reset delay:

- A (RESET_DELAY_BIT+1)-bit counter runs from reset.
- cpu_nreset equals its top bit.
- The counter stops once the top bit is 1.
- The bus is accepted regardless of cpu_nreset.

## Timing

- On nreset low, asynchronously:
  - all LOAD, CTRL, COUNT and flag cleared
  - led = 0, irq = 0, rdata = 0, rvalid = 0
  - cpu_nreset = 0, delay counter = 0
- Reads: sel & ~wr at edge N gives rdata and rvalid = 1 after edge N+1. rvalid is a one-cycle pulse.
- rdata holds its last value when rvalid = 0.
- Writes take effect at the edge where sel & wr is sampled.
- A read of COUNT returns the value before that edge's decrement.
- irq is combinational from registered flag and irq_en, so it rises the cycle after the expiry edge.
- Simultaneous expiry and STATUS clear write on the same channel: set wins, flag stays 1.
- Simultaneous expiry and a CTRL write clearing enable: the write wins. No expiry, no toggle, no flag.
- cpu_nreset rises exactly 2^RESET_DELAY_BIT rising edges after nreset deasserts.
- nreset asserted mid-count aborts everything immediately. After release, counting resumes only on a new enable write.

## Test plan

- Reset delay: RESET_DELAY_BIT=3, release nreset -> cpu_nreset low for 8 edges, high from the 8th edge onward. All outputs 0 during reset.
- Periodic: ch0 LOAD=4, CTRL=0b111 -> flag and led[0] toggle every 5 cycles; irq high until STATUS write 1. Read COUNT sequence is 4,3,2,1,0,4.
- One-shot: ch1 LOAD=2, CTRL=0b001 -> single expiry 3 cycles after the write, led[1] toggles once, CTRL reads 0b000, COUNT stays 0, irq stays 0.
- Collision: ch0 LOAD=3, periodic, STATUS clear timed to the expiry edge -> flag reads 1 afterwards. A clear one cycle later -> flag 0.
- Bus edges: read LOAD after writing 0xFFFF_FFFF with TIMER_BITS=24 -> 0x00FF_FFFF with rvalid one cycle after sel. Read of channel index ≥ CHANNELS -> 0. Write to COUNT -> COUNT unchanged.
- Mid-operation reset: assert nreset while ch0 periodic LOAD=10 is counting -> led, irq and COUNT are 0 immediately. No expiry occurs after release without a new enable.
